// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: IF req/addr_ok/data_ok handshake to a single-beat, in-order AXI4 read master.
// Optional R-channel register stage and sticky bus_err under INST_BRIDGE_RSKID_EN.
module inst_fetch_bridge #(
    parameter logic [3:0] ARID     = 4'd0,
    parameter int         MAX_OUTS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_inst_req,
    input  logic [2:0]  read_inst_size,
    input  logic [31:0] read_inst_addr,
    output logic        read_inst_addr_ok,
    output logic        read_inst_out_req,
    output logic [31:0] read_inst,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTS);

    logic [2:0] outs_cnt;
    logic       beat;

    assign arid    = ARID;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign rready  = 1'b1;

    // The limit compare uses the registered count so no combinational path runs from R to AR.
    assign read_inst_addr_ok = !reset && read_inst_req && !arvalid && (outs_cnt < MAX_CNT);
    assign beat              = !reset && rvalid && rlast && (outs_cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid <= 1'b0;
            araddr  <= 32'd0;
            arsize  <= 3'd0;
        end else if (read_inst_addr_ok) begin
            arvalid <= 1'b1;
            araddr  <= read_inst_addr;
            arsize  <= read_inst_size;
        end else if (arvalid && arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outs_cnt <= 3'd0;
        end else begin
            case ({read_inst_addr_ok, beat})
                2'b10:   outs_cnt <= outs_cnt + 3'd1;
                2'b01:   outs_cnt <= outs_cnt - 3'd1;
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

`ifdef INST_BRIDGE_RSKID_EN
    logic unused_bits;
    assign unused_bits = ^rid;

    always_ff @(posedge clk) begin
        if (reset) begin
            read_inst_out_req <= 1'b0;
            read_inst         <= 32'd0;
            bus_err           <= 1'b0;
        end else begin
            read_inst_out_req <= beat;
            if (beat) begin
                read_inst <= rdata;
            end
            if (beat && (rresp != 2'b00)) begin
                bus_err <= 1'b1;
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{rid, rresp};

    assign read_inst_out_req = beat;
    assign read_inst         = rdata;
    assign bus_err           = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed literal scenarios, then randomized traffic
// against a queue-based behavioural model with an in-order AXI slave.
module tb_inst_fetch_bridge;

`ifdef INST_BRIDGE_RSKID_EN
    localparam int LAT     = 1;
    localparam bit EXP_ERR = 1'b1;
`else
    localparam int LAT     = 0;
    localparam bit EXP_ERR = 1'b0;
`endif
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_inst_req;
    logic [2:0]  read_inst_size;
    logic [31:0] read_inst_addr;
    logic        read_inst_addr_ok;
    logic        read_inst_out_req;
    logic [31:0] read_inst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_err;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] got[$];

    inst_fetch_bridge #(.ARID(4'd0), .MAX_OUTS(MAXO)) dut (
        .clk(clk), .reset(reset),
        .read_inst_req(read_inst_req), .read_inst_size(read_inst_size),
        .read_inst_addr(read_inst_addr), .read_inst_addr_ok(read_inst_addr_ok),
        .read_inst_out_req(read_inst_out_req), .read_inst(read_inst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (read_inst_out_req) got.push_back(read_inst);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a ^ 32'h5a5a_c3c3) + 32'h0000_0101;
    endfunction

    // behavioural model state
    bit          m_pend;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    int          m_n;
    logic [31:0] m_exp[$];
    logic [31:0] s_q[$];
    bit          m_err;
    bit          m_oreq_d;
    logic [31:0] m_odata_d;

    initial begin
        reset = 1'b1; read_inst_req = 1'b1; read_inst_addr = 32'h1c00_0000;
        read_inst_size = 3'b010; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rdata = 32'd0; rresp = 2'b00; rid = 4'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", 32'(read_inst_addr_ok), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_out_req", 32'(read_inst_out_req), 32'd0);
        chk("rst_cnt", 32'(dut.outs_cnt), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);

        // single fetch
        @(posedge clk); #1 reset = 1'b0; arready = 1'b1; got.delete();
        @(negedge clk); chk("sf_addr_ok", 32'(read_inst_addr_ok), 32'd1);
        @(posedge clk); #1 read_inst_req = 1'b0;
        @(negedge clk);
        chk("sf_arvalid", 32'(arvalid), 32'd1);
        chk("sf_araddr", araddr, 32'h1c00_0000);
        chk("sf_arsize", 32'(arsize), 32'd2);
        chk("sf_arlen", 32'(arlen), 32'd0);
        chk("sf_arburst", 32'(arburst), 32'd1);
        chk("sf_arid", 32'(arid), 32'd0);
        chk("sf_rready", 32'(rready), 32'd1);
        chk("sf_cnt1", 32'(dut.outs_cnt), 32'd1);
        @(posedge clk); #1 rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0280_0c05;
        @(negedge clk);
        chk("sf_oreq_beat", 32'(read_inst_out_req), (LAT == 0) ? 32'd1 : 32'd0);
        chk("sf_arvalid_clr", 32'(arvalid), 32'd0);
        @(posedge clk); #1 rvalid = 1'b0;
        @(negedge clk);
        chk("sf_oreq_next", 32'(read_inst_out_req), (LAT == 1) ? 32'd1 : 32'd0);
        chk("sf_read_inst", read_inst, 32'h0280_0c05);
        chk("sf_cnt0", 32'(dut.outs_cnt), 32'd0);

        // spurious beat
        @(posedge clk); #1 rvalid = 1'b1; rdata = 32'hdead_beef;
        @(negedge clk); chk("sp_oreq", 32'(read_inst_out_req), 32'd0);
        @(posedge clk); #1 rvalid = 1'b0;
        @(negedge clk);
        chk("sp_oreq_next", 32'(read_inst_out_req), 32'd0);
        chk("sp_cnt", 32'(dut.outs_cnt), 32'd0);
        chk("sf_npulses", 32'(got.size()), 32'd1);
        chk("sf_pulse0", got[0], 32'h0280_0c05);

        // back-pressure, then outstanding limit
        @(posedge clk); #1 got.delete(); read_inst_req = 1'b1; read_inst_addr = 32'h0000_1000; arready = 1'b0;
        @(negedge clk); chk("bp_accept_a", 32'(read_inst_addr_ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 read_inst_addr = 32'h0000_2000;
            @(negedge clk);
            chk("bp_arvalid", 32'(arvalid), 32'd1);
            chk("bp_araddr", araddr, 32'h0000_1000);
            chk("bp_addr_ok", 32'(read_inst_addr_ok), 32'd0);
        end
        @(posedge clk); #1 arready = 1'b1;
        @(negedge clk); chk("bp_hs_addr_ok", 32'(read_inst_addr_ok), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_accept_b", 32'(read_inst_addr_ok), 32'd1);
        chk("bp_cnt1", 32'(dut.outs_cnt), 32'd1);
        @(posedge clk); #1 read_inst_addr = 32'h0000_3000;
        @(negedge clk);
        chk("lim_araddr_b", araddr, 32'h0000_2000);
        chk("lim_cnt2", 32'(dut.outs_cnt), 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lim_arvalid0", 32'(arvalid), 32'd0);
        chk("lim_block", 32'(read_inst_addr_ok), 32'd0);
        @(posedge clk); #1 rvalid = 1'b1; rlast = 1'b1; rdata = 32'haaaa_0001; rresp = 2'b10;
        @(negedge clk); chk("lim_same_cycle", 32'(read_inst_addr_ok), 32'd0);
        @(posedge clk); #1 rvalid = 1'b0; rresp = 2'b00;
        @(negedge clk);
        chk("lim_accept_c", 32'(read_inst_addr_ok), 32'd1);
        chk("lim_cnt1", 32'(dut.outs_cnt), 32'd1);
        @(posedge clk); #1 read_inst_req = 1'b0;
        @(negedge clk);
        chk("lim_araddr_c", araddr, 32'h0000_3000);
        chk("err_flag", 32'(bus_err), 32'(EXP_ERR));
        @(posedge clk); #1 rvalid = 1'b1; rdata = 32'haaaa_0002;
        @(posedge clk); #1 rdata = 32'haaaa_0003;
        @(posedge clk); #1 rvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("lim_cnt_end", 32'(dut.outs_cnt), 32'd0);
        chk("lim_npulses", 32'(got.size()), 32'd3);
        chk("lim_order0", got[0], 32'haaaa_0001);
        chk("lim_order1", got[1], 32'haaaa_0002);
        chk("lim_order2", got[2], 32'haaaa_0003);
        chk("err_sticky", 32'(bus_err), 32'(EXP_ERR));

        // reset mid-flight
        @(posedge clk); #1 read_inst_req = 1'b1; read_inst_addr = 32'h0000_4000; arready = 1'b0;
        @(negedge clk); chk("mr_accept", 32'(read_inst_addr_ok), 32'd1);
        @(posedge clk); #1 read_inst_req = 1'b0;
        @(negedge clk);
        chk("mr_arvalid", 32'(arvalid), 32'd1);
        chk("mr_cnt1", 32'(dut.outs_cnt), 32'd1);
        @(posedge clk); #1 reset = 1'b1; read_inst_req = 1'b1;
        @(negedge clk);
        chk("mr_rst_addr_ok", 32'(read_inst_addr_ok), 32'd0);
        chk("mr_rst_oreq", 32'(read_inst_out_req), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mr_arvalid0", 32'(arvalid), 32'd0);
        chk("mr_cnt0", 32'(dut.outs_cnt), 32'd0);
        chk("mr_bus_err0", 32'(bus_err), 32'd0);
        chk("mr_oreq0", 32'(read_inst_out_req), 32'd0);
        chk("mr_reaccept", 32'(read_inst_addr_ok), 32'd1);
        @(posedge clk); #1 reset = 1'b1; read_inst_req = 1'b0;

        // randomized traffic against the model; first edge below is a reset edge
        m_pend = 1'b0; m_addr = '0; m_size = '0; m_n = 0; m_err = 1'b0;
        m_oreq_d = 1'b0; m_odata_d = '0; m_exp.delete(); s_q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit          e_ok, e_beat, e_oreq;
            logic [31:0] e_data;
            @(posedge clk); #1;
            reset          = (cyc > 0) && ($urandom_range(0, 199) == 0);
            read_inst_req  = ($urandom_range(0, 9) < 7);
            read_inst_addr = $urandom & 32'hffff_fffc;
            read_inst_size = 3'($urandom_range(0, 7));
            arready        = ($urandom_range(0, 9) < 6);
            rid            = 4'($urandom);
            rresp          = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rlast          = 1'b1;
            rdata          = $urandom;
            rvalid         = 1'b0;
            if (s_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                rvalid = 1'b1;
                rdata  = mem_word(s_q[0]);
            end else if (m_n == 0 && $urandom_range(0, 9) == 0) begin
                rvalid = 1'b1;
            end
            @(negedge clk);
            e_ok   = !reset && read_inst_req && !m_pend && (m_n < MAXO);
            e_beat = !reset && rvalid && rlast && (m_n != 0);
            e_oreq = (LAT == 0) ? e_beat : m_oreq_d;
            e_data = (LAT == 0) ? ((m_exp.size() != 0) ? mem_word(m_exp[0]) : 32'd0) : m_odata_d;
            chk("rnd_addr_ok", 32'(read_inst_addr_ok), 32'(e_ok));
            chk("rnd_arvalid", 32'(arvalid), 32'(m_pend));
            if (m_pend) begin
                chk("rnd_araddr", araddr, m_addr);
                chk("rnd_arsize", 32'(arsize), 32'(m_size));
            end
            chk("rnd_cnt", 32'(dut.outs_cnt), 32'(m_n));
            chk("rnd_out_req", 32'(read_inst_out_req), 32'(e_oreq));
            if (e_oreq) chk("rnd_read_inst", read_inst, e_data);
            chk("rnd_bus_err", 32'(bus_err), 32'(m_err));

            if (reset) begin
                m_pend = 1'b0; m_addr = '0; m_size = '0; m_n = 0; m_err = 1'b0;
                m_oreq_d = 1'b0; m_odata_d = '0; m_exp.delete(); s_q.delete();
            end else begin
                m_oreq_d = e_beat;
                if (e_beat) begin
                    m_odata_d = mem_word(m_exp[0]);
                    if (LAT == 1 && rresp != 2'b00) m_err = 1'b1;
                    void'(m_exp.pop_front());
                    void'(s_q.pop_front());
                end
                if (m_pend && arready) begin
                    s_q.push_back(m_addr);
                    m_pend = 1'b0;
                end
                if (e_ok) begin
                    m_pend = 1'b1;
                    m_addr = read_inst_addr;
                    m_size = read_inst_size;
                    m_exp.push_back(read_inst_addr);
                end
                m_n = m_n + int'(e_ok) - int'(e_beat);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
